// File: rtl/pmem_line_arbiter.sv
// pmem_line_arbiter: N-port line-granularity arbiter onto the single physical-memory line port.
// Optional memory-error return is enabled by defining PMEM_LINE_ARB_ERROR_EN.

module pmem_line_arbiter_chk #(
  parameter int N_PORTS = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_PORTS-1:0] req_read,
  input  logic [N_PORTS-1:0] req_write
);
  // A port raising read and write together is resolved as a write, but is a requester bug.
  a_rw_exclusive: assert property (@(posedge clk) disable iff (reset)
    ((req_read & req_write) == {N_PORTS{1'b0}}));
endmodule

module pmem_line_arbiter #(
  parameter int N_PORTS        = 2,
  parameter int LINE_WIDTH     = 256,
  parameter int ADDR_WIDTH     = 32,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_PORTS-1:0]            req_read,
  input  logic [N_PORTS-1:0]            req_write,
  input  logic [N_PORTS*ADDR_WIDTH-1:0] req_address,
  input  logic [N_PORTS*LINE_WIDTH-1:0] req_wdata,
  output logic [N_PORTS-1:0]            req_resp,
  output logic [LINE_WIDTH-1:0]         req_rdata,
`ifdef PMEM_LINE_ARB_ERROR_EN
  input  logic                          pmem_error,
  output logic [N_PORTS-1:0]            req_error,
`endif
  input  logic                          pmem_resp,
  input  logic [LINE_WIDTH-1:0]         pmem_rdata,
  output logic                          pmem_read,
  output logic                          pmem_write,
  output logic [ADDR_WIDTH-1:0]         pmem_address,
  output logic [LINE_WIDTH-1:0]         pmem_wdata
);
  localparam int GW          = $clog2(N_PORTS);
  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK    = {ADDR_WIDTH{1'b1}} << OFFSET_BITS;
  localparam logic [N_PORTS-1:0]    PORT0_ONEHOT = {{(N_PORTS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t                  state_r;
  state_t                  state_next_s;
  logic [N_PORTS-1:0]      req_any_s;
  logic [GW-1:0]           win_s;
  logic [GW-1:0]           grant_r;
  logic [GW-1:0]           last_grant_r;
  logic                    err_s;
  logic                    finish_s;
  logic [ADDR_WIDTH-1:0]   addr_a_s  [N_PORTS];
  logic [LINE_WIDTH-1:0]   wdata_a_s [N_PORTS];

  for (genvar p = 0; p < N_PORTS; p++) begin : g_unpack
    assign addr_a_s[p]  = req_address[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a_s[p] = req_wdata[p*LINE_WIDTH +: LINE_WIDTH];
  end

  assign req_any_s = req_read | req_write;
`ifdef PMEM_LINE_ARB_ERROR_EN
  assign err_s = pmem_error;
`else
  assign err_s = 1'b0;
`endif
  assign finish_s = pmem_resp | err_s;

  // Winner selection: scan upward from last_grant_r+1 with wrap, or from index 0 in fixed mode.
  always_comb begin
    int            idx;
    logic [GW-1:0] idx_s;
    logic          found;
    win_s = {GW{1'b0}};
    found = 1'b0;
    idx   = 32'sd0;
    idx_s = {GW{1'b0}};
    for (int k = 1; k <= N_PORTS; k++) begin
      if (FIXED_PRIORITY != 0) begin
        idx = k - 1;
      end else begin
        idx = (int'(last_grant_r) + k) % N_PORTS;
      end
      idx_s = GW'(idx);
      if (!found && req_any_s[idx_s]) begin
        win_s = idx_s;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (|req_any_s) state_next_s = BUSY;
        else            state_next_s = IDLE;
      end
      BUSY: begin
        if (finish_s) state_next_s = DONE;
        else          state_next_s = BUSY;
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Request capture, pmem strobes and the one-cycle response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_r      <= {GW{1'b0}};
      last_grant_r <= GW'(N_PORTS - 1);
      req_resp     <= {N_PORTS{1'b0}};
      req_rdata    <= {LINE_WIDTH{1'b0}};
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= {ADDR_WIDTH{1'b0}};
      pmem_wdata   <= {LINE_WIDTH{1'b0}};
`ifdef PMEM_LINE_ARB_ERROR_EN
      req_error    <= {N_PORTS{1'b0}};
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (|req_any_s) begin
            grant_r      <= win_s;
            pmem_read    <= ~req_write[win_s];
            pmem_write   <= req_write[win_s];
            pmem_address <= addr_a_s[win_s] & LINE_MASK;
            pmem_wdata   <= wdata_a_s[win_s];
          end
        end
        BUSY: begin
          // pmem_write still holds the captured op, so it also selects write-vs-read data.
          if (finish_s) begin
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            req_resp   <= PORT0_ONEHOT << grant_r;
            req_rdata  <= (pmem_write || err_s) ? {LINE_WIDTH{1'b0}} : pmem_rdata;
`ifdef PMEM_LINE_ARB_ERROR_EN
            req_error  <= err_s ? (PORT0_ONEHOT << grant_r) : {N_PORTS{1'b0}};
`endif
          end
        end
        DONE: begin
          req_resp  <= {N_PORTS{1'b0}};
          req_rdata <= {LINE_WIDTH{1'b0}};
`ifdef PMEM_LINE_ARB_ERROR_EN
          req_error <= {N_PORTS{1'b0}};
`endif
          if (FIXED_PRIORITY == 0) begin
            last_grant_r <= grant_r;
          end
        end
        default: begin
          req_resp <= {N_PORTS{1'b0}};
        end
      endcase
    end
  end

  pmem_line_arbiter_chk #(.N_PORTS(N_PORTS)) u_chk (
    .clk       (clk),
    .reset     (reset),
    .req_read  (req_read),
    .req_write (req_write)
  );
endmodule

// File: tb/tb_pmem_line_arbiter.sv
// Randomized self-checking bench for pmem_line_arbiter: a round-robin 2-port instance and a
// fixed-priority 4-port instance, checked against a transaction-level reference model.
module tb_pmem_line_arbiter;
  localparam int LW = 256;
  localparam int AW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [3:0]      rd_s, wr_s;
  logic [4*AW-1:0] addr_bus;
  logic [4*LW-1:0] wd_bus;
  logic            pmem_resp_s, pmem_error_s;
  logic [LW-1:0]   pmem_rdata_s;
  int              mode;

  logic [1:0]    rr_rd_in, rr_wr_in, rr_resp, rr_err;
  logic          rr_pr_in, rr_pe_in, rr_rd, rr_wr;
  logic [LW-1:0] rr_rdata, rr_wdata;
  logic [AW-1:0] rr_addr;
  logic [3:0]    fp_rd_in, fp_wr_in, fp_resp, fp_err;
  logic          fp_pr_in, fp_pe_in, fp_rd, fp_wr;
  logic [LW-1:0] fp_rdata, fp_wdata;
  logic [AW-1:0] fp_addr;

  assign rr_rd_in = (mode == 0) ? rd_s[1:0] : 2'b00;
  assign rr_wr_in = (mode == 0) ? wr_s[1:0] : 2'b00;
  assign rr_pr_in = (mode == 0) && pmem_resp_s;
  assign rr_pe_in = (mode == 0) && pmem_error_s;
  assign fp_rd_in = (mode == 1) ? rd_s : 4'b0000;
  assign fp_wr_in = (mode == 1) ? wr_s : 4'b0000;
  assign fp_pr_in = (mode == 1) && pmem_resp_s;
  assign fp_pe_in = (mode == 1) && pmem_error_s;

  pmem_line_arbiter #(.N_PORTS(2), .LINE_WIDTH(LW), .ADDR_WIDTH(AW), .FIXED_PRIORITY(0)) dut_rr (
    .clk(clk), .reset(reset), .req_read(rr_rd_in), .req_write(rr_wr_in),
    .req_address(addr_bus[2*AW-1:0]), .req_wdata(wd_bus[2*LW-1:0]),
    .req_resp(rr_resp), .req_rdata(rr_rdata),
`ifdef PMEM_LINE_ARB_ERROR_EN
    .pmem_error(rr_pe_in), .req_error(rr_err),
`endif
    .pmem_resp(rr_pr_in), .pmem_rdata(pmem_rdata_s), .pmem_read(rr_rd), .pmem_write(rr_wr),
    .pmem_address(rr_addr), .pmem_wdata(rr_wdata));

  pmem_line_arbiter #(.N_PORTS(4), .LINE_WIDTH(LW), .ADDR_WIDTH(AW), .FIXED_PRIORITY(1)) dut_fp (
    .clk(clk), .reset(reset), .req_read(fp_rd_in), .req_write(fp_wr_in),
    .req_address(addr_bus), .req_wdata(wd_bus),
    .req_resp(fp_resp), .req_rdata(fp_rdata),
`ifdef PMEM_LINE_ARB_ERROR_EN
    .pmem_error(fp_pe_in), .req_error(fp_err),
`endif
    .pmem_resp(fp_pr_in), .pmem_rdata(pmem_rdata_s), .pmem_read(fp_rd), .pmem_write(fp_wr),
    .pmem_address(fp_addr), .pmem_wdata(fp_wdata));

`ifndef PMEM_LINE_ARB_ERROR_EN
  assign rr_err = 2'b00;
  assign fp_err = 4'b0000;
`endif

  // Observed outputs of whichever instance is under test.
  logic [3:0]    o_resp, o_err;
  logic [LW-1:0] o_rdata, o_wdata;
  logic          o_rd, o_wr;
  logic [AW-1:0] o_addr;
  always_comb begin
    if (mode == 0) begin
      o_resp = {2'b00, rr_resp}; o_err = {2'b00, rr_err}; o_rdata = rr_rdata;
      o_wdata = rr_wdata; o_rd = rr_rd; o_wr = rr_wr; o_addr = rr_addr;
    end else begin
      o_resp = fp_resp; o_err = fp_err; o_rdata = fp_rdata;
      o_wdata = fp_wdata; o_rd = fp_rd; o_wr = fp_wr; o_addr = fp_addr;
    end
  end

  // Reference model: requester contents plus the arbitration history.
  logic [3:0]    act, is_wr;
  logic [AW-1:0] a_q [4];
  logic [LW-1:0] w_q [4];
  int            np, last_g;
  bit            fixed;
  int            n_chk, n_pass;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      rd_s[i] = act[i] & ~is_wr[i];
      wr_s[i] = act[i] & is_wr[i];
      addr_bus[i*AW +: AW] = a_q[i];
      wd_bus[i*LW +: LW]   = w_q[i];
    end
  endtask

  task automatic new_req(input int i);
    act[i]   = 1'b1;
    is_wr[i] = 1'($urandom_range(0, 1));
    a_q[i]   = $urandom();
    w_q[i]   = rand_line();
  endtask

  task automatic fill_random();
    bit any;
    any = 1'b0;
    for (int i = 0; i < np; i++) begin
      if (!act[i] && $urandom_range(0, 1) == 1) new_req(i);
      if (act[i]) any = 1'b1;
    end
    if (!any) new_req(int'($urandom_range(0, np - 1)));
  endtask

  // Next winner: first active port after last_g (wrapping), or the lowest active port.
  function automatic int pick();
    int idx;
    for (int k = 1; k <= np; k++) begin
      idx = fixed ? k - 1 : (last_g + k) % np;
      if (act[idx]) return idx;
    end
    return 0;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    act = 4'b0000;
    drive();
    tick();
    tick();
    reset = 1'b0;
    last_g = np - 1;
  endtask

  // One complete transaction starting in an IDLE cycle; err: 0 none, 1 error+resp, 2 error alone.
  task automatic run_txn(input int lat, input logic [LW-1:0] line, input int err);
    int            g;
    logic [3:0]    exp_oh;
    logic [LW-1:0] exp_data;
    drive();
    g = pick();
    exp_oh = 4'b0001 << g;
    tick();
    check("pmem_wdata", o_wdata, w_q[g]);
    for (int c = 1; c <= lat; c++) begin
      check("pmem_read", o_rd, !is_wr[g]);
      check("pmem_write", o_wr, is_wr[g]);
      check("pmem_address", o_addr, a_q[g] - (a_q[g] % 32'd32));
      check("early_resp", o_resp, 4'b0000);
      if (c == lat) begin
        pmem_resp_s  = (err != 2);
        pmem_error_s = (err != 0);
        pmem_rdata_s = line;
      end
      tick();
    end
    pmem_resp_s  = 1'b0;
    pmem_error_s = 1'b0;
    pmem_rdata_s = rand_line();
    exp_data = (is_wr[g] || err != 0) ? '0 : line;
    check("req_resp", o_resp, exp_oh);
    check("req_rdata", o_rdata, exp_data);
    check("strobes_off", {o_rd, o_wr}, 2'b00);
`ifdef PMEM_LINE_ARB_ERROR_EN
    check("req_error", o_err, (err != 0) ? exp_oh : 4'b0000);
`endif
    act[g] = 1'b0;
    if (!fixed) last_g = g;
    tick();
    check("resp_one_cycle", o_resp, 4'b0000);
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    reset = 1'b1; mode = 0; np = 2; fixed = 1'b0;
    act = 4'b0000; is_wr = 4'b0000;
    for (int i = 0; i < 4; i++) begin a_q[i] = '0; w_q[i] = '0; end
    pmem_resp_s = 1'b0; pmem_error_s = 1'b0; pmem_rdata_s = '0;
    drive();
    do_reset();
    check("rst_resp", o_resp, 4'b0000);
    check("rst_rdata", o_rdata, '0);
    check("rst_strobes", {o_rd, o_wr}, 2'b00);
    check("rst_address", o_addr, '0);
    check("rst_wdata", o_wdata, '0);

    // Single port-0 read, latency 5, A5 line.
    act[0] = 1'b1; is_wr[0] = 1'b0; a_q[0] = 32'h0000_1234; w_q[0] = rand_line();
    run_txn(5, {32{8'hA5}}, 0);

    // Both ports reading continuously: expect alternation.
    do_reset();
    is_wr = 4'b0000; act = 4'b0011;
    for (int n = 0; n < 4; n++) begin
      run_txn(int'($urandom_range(1, 3)), rand_line(), 0);
      act[1:0] = 2'b11;
    end
    act = 4'b0000;

    // Port-1 write.
    act[1] = 1'b1; is_wr[1] = 1'b1; a_q[1] = 32'h0000_0040; w_q[1] = {8{32'hDEAD_BEEF}};
    run_txn(2, rand_line(), 0);

    // pmem_resp while idle is ignored.
    drive();
    pmem_resp_s = 1'b1;
    tick();
    pmem_resp_s = 1'b0;
    check("idle_resp_ignored", {o_resp, o_rd, o_wr}, 6'b000000);

    // Reset in the middle of a read.
    act[1] = 1'b1; is_wr[1] = 1'b0; a_q[1] = $urandom(); w_q[1] = rand_line();
    drive();
    tick();
    check("busy_before_reset", o_rd, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    last_g = np - 1;
    check("reset_mid_strobes", {o_rd, o_wr}, 2'b00);
    check("reset_mid_resp", o_resp, 4'b0000);
    run_txn(1, rand_line(), 0);

`ifdef PMEM_LINE_ARB_ERROR_EN
    act[1] = 1'b1; is_wr[1] = 1'b0;
    run_txn(3, rand_line(), 1);
    act[0] = 1'b1; is_wr[0] = 1'b0;
    run_txn(2, rand_line(), 0);
    act[1] = 1'b1; is_wr[1] = 1'b0;
    run_txn(2, rand_line(), 2);
`endif

    repeat (40) begin
      fill_random();
      run_txn(int'($urandom_range(1, 6)), rand_line(), 0);
    end

    // Fixed-priority 4-port instance.
    mode = 1; np = 4; fixed = 1'b1;
    do_reset();
    act = 4'b1001; is_wr = 4'b0000;
    a_q[0] = $urandom(); a_q[3] = $urandom();
    for (int n = 0; n < 3; n++) begin
      run_txn(int'($urandom_range(1, 3)), rand_line(), 0);
      act[0] = 1'b1;
    end
    act[0] = 1'b0;
    run_txn(2, rand_line(), 0);
    repeat (40) begin
      fill_random();
      run_txn(int'($urandom_range(1, 6)), rand_line(), 0);
    end
    act = 4'b0000;
    drive();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
